turfio_rxclk_ps_ctrl: RTL and testbench
=======================================

TURFIO_RXCLK_PS_CTRL -- requirements
Module: turfio_rxclk_ps_ctrl

Interface
REQ-001 Parameter PHASE_STEPS, default 672, fine-PS increments per full RXCLK period (56 per VCO period x divide 12).
REQ-002 Parameter RST_CYCLES, default 16, MMCM reset pulse length in ps_clk_i cycles.
REQ-003 Parameter PS_TIMEOUT, default 63, max cycles from ps_en_o to ps_done_i.
REQ-004 Parameter LOCK_TIMEOUT, default 65535, max cycles from reset release to lock.
REQ-005 Clock and reset are decided: one clock; reset is synchronous and active-high.
REQ-006 ps_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 cmd_valid_i  in  1  command request.
REQ-009 cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o.
REQ-010 cmd_op_i  in  2  00 STEP (relative), 01 GOTO (absolute), 10 MMCM reset, 11 reserved.
REQ-011 cmd_arg_i  in  10  step count (STEP) or target phase (GOTO); ignored otherwise.
REQ-012 mmcm_rst_o  out  1  drives MMCM RST.
REQ-013 mmcm_locked_i  in  1  MMCM LOCKED, asynchronous to ps_clk_i.
REQ-014 ps_en_o  out  1  drives MMCM PSEN (PSINCDEC fixed to increment).
REQ-015 ps_done_i  in  1  MMCM PSDONE.
REQ-016 busy_o  out  1  high in any state except IDLE.
REQ-017 locked_o  out  1  synchronized lock status.
REQ-018 phase_o  out  10  current phase, 0..PHASE_STEPS-1.
REQ-019 err_o  out  1  sticky error flag; err_code_o  out  2  01 PS timeout, 10 lock timeout/loss, 11 bad command.

Function
REQ-020 mmcm_locked_i SHALL pass a 2-flop synchronizer (ASYNC_REG); locked_o is its output; all lock decisions use it.
REQ-021 States: MRST, WAIT_LOCK, IDLE, PS_ISSUE, PS_WAIT.
REQ-022 cmd_ready_o SHALL be 1 only in IDLE; acceptance clears err_o/err_code_o.
REQ-023 MRST: mmcm_rst_o=1 for exactly RST_CYCLES cycles, phase_o cleared to 0, then WAIT_LOCK.
REQ-024 WAIT_LOCK: mmcm_rst_o=0; on synchronized lock -> IDLE; after LOCK_TIMEOUT cycles without lock -> err code 10, re-enter MRST.
REQ-025 STEP with arg N: remaining=N; N=0 completes immediately (stays IDLE, no ps_en_o).
REQ-026 GOTO with arg T<PHASE_STEPS: remaining=(T-phase_o) mod PHASE_STEPS, computed in 11 bits, no underflow; T=phase_o issues no steps.
REQ-027 GOTO with T>=PHASE_STEPS or op 11: rejected, err code 11, stays IDLE, phase unchanged.
REQ-028 Op 10: enter MRST.
REQ-029 PS_ISSUE: ps_en_o=1 for exactly one cycle, then PS_WAIT; ps_en_o never high in any other state.
REQ-030 PS_WAIT: on ps_done_i, phase_o increments, wrapping PHASE_STEPS-1 -> 0; remaining decrements; remaining 0 -> IDLE, else PS_ISSUE. Back-to-back step spacing SHALL be >=2 cycles after ps_done_i.
REQ-031 PS_WAIT timeout: no ps_done_i within PS_TIMEOUT cycles -> err code 01, enter MRST (phase unknown, reset restores 0).
REQ-032 ps_done_i outside PS_WAIT SHALL be ignored.
REQ-033 Loss of synchronized lock in IDLE, PS_ISSUE or PS_WAIT -> err code 10, enter MRST; pending steps discarded.
REQ-034 Simultaneous ps_done_i and lock loss: lock loss wins; phase_o not incremented.
REQ-035 An error occurring while err_o is already set overwrites err_code_o with the newest code.

Reset
REQ-036 rst_i SHALL force state MRST with reset counter 0, mmcm_rst_o=1, ps_en_o=0, cmd_ready_o=0, busy_o=1, phase_o=0, err_o=0, err_code_o=00, synchronizer flops 0.
REQ-037 rst_i mid-step SHALL abort immediately; a ps_done_i arriving afterward is ignored.

Verification
REQ-038 Power-up: rst_i 1 cycle, lock model asserts 10 cycles after mmcm_rst_o falls -> mmcm_rst_o high exactly 16 cycles, IDLE after lock+2 sync cycles, phase_o=0.
REQ-039 STEP 5, ps_done_i 12 cycles after each ps_en_o -> exactly 5 one-cycle ps_en_o pulses, phase_o=5, busy_o falls after last done.
REQ-040 phase_o=670, GOTO 2 -> 4 pulses, phase_o sequence 671,0,1,2; GOTO 700 -> err_code_o=11, no pulses.
REQ-041 STEP 3, ps_done_i suppressed -> err_code_o=01 after 63 cycles, mmcm_rst_o asserted, phase_o=0 after relock.
REQ-042 Lock deasserted during STEP 10 after 4 dones, same cycle as a done -> phase_o not incremented past 4, err_code_o=10, MRST entered.
REQ-043 Lock never asserts -> err_code_o=10 after 65535 cycles in WAIT_LOCK, MRST repeats.

Source files
------------

// File: rtl/turfio_rxclk_ps_ctrl.sv
// RXCLK MMCM fine phase-shift controller.
// Owns MMCM reset, lock tracking and PSEN stepping.
`timescale 1ns/1ps
module turfio_rxclk_ps_ctrl #(
  parameter int PHASE_STEPS  = 672,
  parameter int RST_CYCLES   = 16,
  parameter int PS_TIMEOUT   = 63,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic       ps_clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_op_i,
  input  logic [9:0] cmd_arg_i,
  output logic       mmcm_rst_o,
  input  logic       mmcm_locked_i,
  output logic       ps_en_o,
  input  logic       ps_done_i,
  output logic       busy_o,
  output logic       locked_o,
  output logic [9:0] phase_o,
  output logic       err_o,
  output logic [1:0] err_code_o
);

  localparam int CW = 17;

  localparam logic [1:0] OP_STEP = 2'b00;
  localparam logic [1:0] OP_GOTO = 2'b01;
  localparam logic [1:0] OP_MRST = 2'b10;

  localparam logic [1:0] E_PS   = 2'b01;
  localparam logic [1:0] E_LOCK = 2'b10;
  localparam logic [1:0] E_CMD  = 2'b11;

  typedef enum logic [2:0] {
    S_MRST,
    S_WAIT_LOCK,
    S_IDLE,
    S_PS_ISSUE,
    S_PS_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [10:0]   rem_q, rem_d;
  logic          gap_q, gap_d;
  logic [9:0]    phase_q, phase_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          mmcm_rst_q, mmcm_rst_d;
  logic          ps_en_q, ps_en_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q, busy_d;

  (* ASYNC_REG = "TRUE" *) logic sync1_q;
  (* ASYNC_REG = "TRUE" *) logic sync2_q;
  logic sync1_d, sync2_d;

  logic        lock_s;
  logic        accept;
  logic [10:0] arg_ext;
  logic [10:0] ph_ext;
  logic [10:0] goto_rem;
  logic        goto_ok;
  logic [9:0]  phase_inc;

  assign lock_s  = sync2_q;
  assign accept  = cmd_valid_i & cmd_ready_q;
  assign arg_ext = {1'b0, cmd_arg_i};
  assign ph_ext  = {1'b0, phase_q};
  assign goto_ok = arg_ext < 11'(PHASE_STEPS);

  // Forward distance to the target, wrapping through zero.
  assign goto_rem = (arg_ext >= ph_ext)
                  ? (arg_ext - ph_ext)
                  : (arg_ext + 11'(PHASE_STEPS) - ph_ext);

  assign phase_inc = (phase_q == 10'(PHASE_STEPS - 1))
                   ? 10'd0
                   : phase_q + 10'd1;

  // Next-state, counters, phase tracking and error capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    gap_d      = gap_q;
    phase_d    = phase_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    sync1_d    = mmcm_locked_i;
    sync2_d    = sync1_q;

    if (accept) begin
      err_d      = 1'b0;
      err_code_d = 2'b00;
    end

    unique case (state_q)
      S_MRST: begin
        phase_d = 10'd0;
        rem_d   = 11'd0;
        gap_d   = 1'b0;
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          err_d      = 1'b1;
          err_code_d = E_LOCK;
          state_d    = S_MRST;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_IDLE: begin
        if (!lock_s) begin
          err_d      = 1'b1;
          err_code_d = E_LOCK;
          state_d    = S_MRST;
          cnt_d      = '0;
        end else if (accept) begin
          unique case (1'b1)
            cmd_op_i == OP_STEP: begin
              rem_d = arg_ext;
              if (cmd_arg_i != 10'd0) begin
                state_d = S_PS_ISSUE;
              end
            end
            (cmd_op_i == OP_GOTO) && goto_ok: begin
              rem_d = goto_rem;
              if (goto_rem != 11'd0) begin
                state_d = S_PS_ISSUE;
              end
            end
            cmd_op_i == OP_MRST: begin
              state_d = S_MRST;
              cnt_d   = '0;
            end
            default: begin
              err_d      = 1'b1;
              err_code_d = E_CMD;
            end
          endcase
        end
      end

      S_PS_ISSUE: begin
        if (!lock_s) begin
          err_d      = 1'b1;
          err_code_d = E_LOCK;
          state_d    = S_MRST;
          cnt_d      = '0;
        end else begin
          state_d = S_PS_WAIT;
          cnt_d   = '0;
          gap_d   = 1'b0;
        end
      end

      S_PS_WAIT: begin
        if (!lock_s) begin
          err_d      = 1'b1;
          err_code_d = E_LOCK;
          state_d    = S_MRST;
          cnt_d      = '0;
        end else if (gap_q) begin
          // One idle cycle keeps PSEN two cycles clear of PSDONE.
          gap_d   = 1'b0;
          state_d = S_PS_ISSUE;
        end else if (ps_done_i) begin
          phase_d = phase_inc;
          rem_d   = rem_q - 11'd1;
          if (rem_q == 11'd1) begin
            state_d = S_IDLE;
          end else begin
            gap_d = 1'b1;
          end
        end else if (cnt_q == CW'(PS_TIMEOUT - 1)) begin
          err_d      = 1'b1;
          err_code_d = E_PS;
          state_d    = S_MRST;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = S_MRST;
        cnt_d   = '0;
      end
    endcase

    mmcm_rst_d  = (state_d == S_MRST);
    ps_en_d     = (state_d == S_PS_ISSUE);
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and registered outputs; reset lands in MRST.
  always_ff @(posedge ps_clk_i) begin
    if (rst_i) begin
      state_q     <= S_MRST;
      cnt_q       <= '0;
      rem_q       <= '0;
      gap_q       <= 1'b0;
      phase_q     <= '0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      mmcm_rst_q  <= 1'b1;
      ps_en_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      gap_q       <= gap_d;
      phase_q     <= phase_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      mmcm_rst_q  <= mmcm_rst_d;
      ps_en_q     <= ps_en_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign mmcm_rst_o  = mmcm_rst_q;
  assign ps_en_o     = ps_en_q;
  assign busy_o      = busy_q;
  assign locked_o    = sync2_q;
  assign phase_o     = phase_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_turfio_rxclk_ps_ctrl.sv
// Directed bench for turfio_rxclk_ps_ctrl.
// Behavioural MMCM lock and PSDONE models drive the inputs.
`timescale 1ns/1ps
module tb_turfio_rxclk_ps_ctrl;

  logic       ps_clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic [1:0] cmd_op_i = 2'b00;
  logic [9:0] cmd_arg_i = 10'd0;
  logic       mmcm_rst_o;
  logic       mmcm_locked_i = 1'b0;
  logic       ps_en_o;
  logic       ps_done_i = 1'b0;
  logic       busy_o;
  logic       locked_o;
  logic [9:0] phase_o;
  logic       err_o;
  logic [1:0] err_code_o;

  int vec = 0;
  int miss = 0;

  int pulse_cnt = 0;
  int done_seen = 0;
  int done_cnt = 0;
  int lcnt = 0;
  bit lock_en = 1'b1;
  bit done_sup = 1'b0;

  turfio_rxclk_ps_ctrl dut (
    .ps_clk_i      (ps_clk_i),
    .rst_i         (rst_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_op_i      (cmd_op_i),
    .cmd_arg_i     (cmd_arg_i),
    .mmcm_rst_o    (mmcm_rst_o),
    .mmcm_locked_i (mmcm_locked_i),
    .ps_en_o       (ps_en_o),
    .ps_done_i     (ps_done_i),
    .busy_o        (busy_o),
    .locked_o      (locked_o),
    .phase_o       (phase_o),
    .err_o         (err_o),
    .err_code_o    (err_code_o)
  );

  always #5 ps_clk_i = ~ps_clk_i;

  // MMCM model: lock 10 cycles after RST falls; PSDONE 12 after PSEN.
  always @(posedge ps_clk_i) begin
    #1;
    if (mmcm_rst_o !== 1'b0) lcnt = 0;
    else if (lcnt < 20) lcnt++;
    mmcm_locked_i = lock_en && (lcnt > 10);
    ps_done_i = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        ps_done_i = 1'b1;
        done_seen++;
      end
    end
    if (ps_en_o === 1'b1) begin
      pulse_cnt++;
      if (!done_sup) done_cnt = 12;
    end
  end

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    @(negedge ps_clk_i);
    while (cmd_ready_o !== 1'b1 && n < budget) begin
      @(negedge ps_clk_i);
      n++;
    end
    vec++;
    if (cmd_ready_o !== 1'b1) begin
      miss++;
      $display("FAIL wait_ready: cmd_ready_o=%b after %0d cycles, want 1",
               cmd_ready_o, n);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [9:0] arg);
    wait_ready(20000);
    cmd_valid_i = 1'b1;
    cmd_op_i = op;
    cmd_arg_i = arg;
    @(posedge ps_clk_i);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge ps_clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge ps_clk_i);
    vec++;
    if ({mmcm_rst_o, ps_en_o, cmd_ready_o, busy_o} !== 4'b1001) begin
      miss++;
      $display("FAIL reset_ctl: rst,en,rdy,busy=%b want 1001",
               {mmcm_rst_o, ps_en_o, cmd_ready_o, busy_o});
    end
    vec++;
    if ({phase_o, err_o, err_code_o, locked_o} !== 14'd0) begin
      miss++;
      $display("FAIL reset_dat: phase=%0d err=%b code=%b lk=%b want 0",
               phase_o, err_o, err_code_o, locked_o);
    end
  endtask

  task automatic test_powerup;
    int n;
    int m;
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge ps_clk_i);
      if (mmcm_rst_o !== 1'b1) break;
      n++;
    end
    vec++;
    if (n != 16) begin
      miss++;
      $display("FAIL rst_len: mmcm_rst_o high %0d cycles want 16", n);
    end
    m = 0;
    while (cmd_ready_o !== 1'b1 && m < 200) begin
      m++;
      @(negedge ps_clk_i);
    end
    vec++;
    if (m != 13) begin
      miss++;
      $display("FAIL lock_lat: fall-to-idle %0d cycles want 13", m);
    end
    vec++;
    if ({phase_o, locked_o, busy_o} !== {10'd0, 1'b1, 1'b0}) begin
      miss++;
      $display("FAIL idle_st: phase=%0d lk=%b busy=%b want 0,1,0",
               phase_o, locked_o, busy_o);
    end
  endtask

  task automatic test_step5;
    int p0;
    p0 = pulse_cnt;
    send_cmd(2'b00, 10'd5);
    @(negedge ps_clk_i);
    vec++;
    if ({busy_o, cmd_ready_o} !== 2'b10) begin
      miss++;
      $display("FAIL step_busy: busy,rdy=%b want 10",
               {busy_o, cmd_ready_o});
    end
    wait_ready(500);
    vec++;
    if (pulse_cnt - p0 != 5) begin
      miss++;
      $display("FAIL step5_pulses: got %0d want 5", pulse_cnt - p0);
    end
    vec++;
    if (phase_o !== 10'd5 || busy_o !== 1'b0) begin
      miss++;
      $display("FAIL step5_phase: phase=%0d busy=%b want 5,0",
               phase_o, busy_o);
    end
  endtask

  task automatic test_goto;
    int p0;
    int cnt;
    logic [9:0] last;
    logic [9:0] seq [0:7];
    send_cmd(2'b00, 10'd665);
    wait_ready(20000);
    vec++;
    if (phase_o !== 10'd670) begin
      miss++;
      $display("FAIL pre_goto: phase=%0d want 670", phase_o);
    end
    p0 = pulse_cnt;
    send_cmd(2'b01, 10'd2);
    last = phase_o;
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge ps_clk_i);
      if (phase_o !== last) begin
        if (cnt < 8) seq[cnt] = phase_o;
        cnt++;
        last = phase_o;
      end
      if (cmd_ready_o === 1'b1) break;
    end
    vec++;
    if (cnt != 4 || pulse_cnt - p0 != 4) begin
      miss++;
      $display("FAIL goto_cnt: changes=%0d pulses=%0d want 4,4",
               cnt, pulse_cnt - p0);
    end else begin
      vec++;
      if (seq[0] !== 10'd671 || seq[1] !== 10'd0 ||
          seq[2] !== 10'd1 || seq[3] !== 10'd2) begin
        miss++;
        $display("FAIL goto_seq: %0d,%0d,%0d,%0d want 671,0,1,2",
                 seq[0], seq[1], seq[2], seq[3]);
      end
    end
    p0 = pulse_cnt;
    send_cmd(2'b01, 10'd700);
    repeat (3) @(negedge ps_clk_i);
    vec++;
    if ({err_o, err_code_o} !== 3'b111 || pulse_cnt != p0) begin
      miss++;
      $display("FAIL goto_bad: err=%b code=%b pulses=%0d want 1,11,0",
               err_o, err_code_o, pulse_cnt - p0);
    end
    vec++;
    if (phase_o !== 10'd2 || cmd_ready_o !== 1'b1) begin
      miss++;
      $display("FAIL goto_bad_st: phase=%0d rdy=%b want 2,1",
               phase_o, cmd_ready_o);
    end
  endtask

  task automatic test_noop_cmds;
    int p0;
    p0 = pulse_cnt;
    send_cmd(2'b00, 10'd0);
    repeat (3) @(negedge ps_clk_i);
    vec++;
    if ({err_o, err_code_o, busy_o} !== 4'b0000 || pulse_cnt != p0) begin
      miss++;
      $display("FAIL step0: err=%b code=%b busy=%b pulses=%0d want 0",
               err_o, err_code_o, busy_o, pulse_cnt - p0);
    end
    send_cmd(2'b01, 10'd2);
    repeat (3) @(negedge ps_clk_i);
    vec++;
    if (pulse_cnt != p0 || busy_o !== 1'b0 || phase_o !== 10'd2) begin
      miss++;
      $display("FAIL goto_same: pulses=%0d busy=%b phase=%0d want 0,0,2",
               pulse_cnt - p0, busy_o, phase_o);
    end
  endtask

  task automatic test_ps_timeout;
    int p0;
    int n;
    done_sup = 1'b1;
    p0 = pulse_cnt;
    send_cmd(2'b00, 10'd3);
    for (int i = 0; i < 10; i++) begin
      @(negedge ps_clk_i);
      if (ps_en_o === 1'b1) break;
    end
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge ps_clk_i);
      if (err_o === 1'b1) break;
      n++;
    end
    vec++;
    if (n != 63) begin
      miss++;
      $display("FAIL ps_tmo_len: %0d cycles want 63", n);
    end
    vec++;
    if (err_code_o !== 2'b01 || mmcm_rst_o !== 1'b1) begin
      miss++;
      $display("FAIL ps_tmo: code=%b mrst=%b want 01,1",
               err_code_o, mmcm_rst_o);
    end
    vec++;
    if (pulse_cnt - p0 != 1) begin
      miss++;
      $display("FAIL ps_tmo_pulses: %0d want 1", pulse_cnt - p0);
    end
    done_sup = 1'b0;
    wait_ready(300);
    vec++;
    if (phase_o !== 10'd0 || {err_o, err_code_o} !== 3'b101) begin
      miss++;
      $display("FAIL ps_tmo_relock: phase=%0d err=%b code=%b want 0,1,01",
               phase_o, err_o, err_code_o);
    end
  endtask

  task automatic test_lock_loss;
    int p0;
    int d0;
    bit hit;
    p0 = pulse_cnt;
    d0 = done_seen;
    hit = 1'b0;
    send_cmd(2'b00, 10'd10);
    for (int i = 0; i < 500; i++) begin
      @(posedge ps_clk_i);
      #2;
      if (done_seen - d0 == 4 && done_cnt == 3) begin
        lock_en = 1'b0;
        hit = 1'b1;
        break;
      end
    end
    vec++;
    if (!hit) begin
      miss++;
      $display("FAIL ll_setup: dones=%0d want 4 pending 5th",
               done_seen - d0);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge ps_clk_i);
      if (mmcm_rst_o === 1'b1) break;
    end
    vec++;
    if (mmcm_rst_o !== 1'b1 || phase_o !== 10'd4) begin
      miss++;
      $display("FAIL ll_phase: mrst=%b phase=%0d want 1,4",
               mmcm_rst_o, phase_o);
    end
    vec++;
    if ({err_o, err_code_o} !== 3'b110 || done_seen - d0 != 5 ||
        pulse_cnt - p0 != 5) begin
      miss++;
      $display("FAIL ll_err: err=%b code=%b dones=%0d pulses=%0d want 1,10,5,5",
               err_o, err_code_o, done_seen - d0, pulse_cnt - p0);
    end
    lock_en = 1'b1;
    wait_ready(300);
    vec++;
    if (phase_o !== 10'd0) begin
      miss++;
      $display("FAIL ll_relock: phase=%0d want 0", phase_o);
    end
  endtask

  task automatic test_reset_mid;
    int p0;
    p0 = pulse_cnt;
    send_cmd(2'b00, 10'd3);
    for (int i = 0; i < 100; i++) begin
      @(negedge ps_clk_i);
      if (pulse_cnt - p0 == 2) break;
    end
    vec++;
    if (phase_o !== 10'd1) begin
      miss++;
      $display("FAIL mid_pre: phase=%0d want 1", phase_o);
    end
    rst_i = 1'b1;
    @(posedge ps_clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge ps_clk_i);
    vec++;
    if ({mmcm_rst_o, ps_en_o, cmd_ready_o, busy_o, locked_o} !== 5'b10010 ||
        phase_o !== 10'd0) begin
      miss++;
      $display("FAIL mid_rst: rst,en,rdy,busy,lk=%b phase=%0d want 10010,0",
               {mmcm_rst_o, ps_en_o, cmd_ready_o, busy_o, locked_o}, phase_o);
    end
    wait_ready(300);
    vec++;
    if (phase_o !== 10'd0 || pulse_cnt - p0 != 2) begin
      miss++;
      $display("FAIL mid_after: phase=%0d pulses=%0d want 0,2",
               phase_o, pulse_cnt - p0);
    end
  endtask

  task automatic test_lock_never;
    int n;
    send_cmd(2'b11, 10'd0);
    @(negedge ps_clk_i);
    vec++;
    if ({err_o, err_code_o} !== 3'b111) begin
      miss++;
      $display("FAIL op11: err=%b code=%b want 1,11", err_o, err_code_o);
    end
    lock_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ps_clk_i);
      if (mmcm_rst_o === 1'b1) break;
    end
    vec++;
    if (mmcm_rst_o !== 1'b1 || err_code_o !== 2'b10) begin
      miss++;
      $display("FAIL overwrite: mrst=%b code=%b want 1,10",
               mmcm_rst_o, err_code_o);
    end
    for (int i = 0; i < 40; i++) begin
      if (mmcm_rst_o === 1'b0) break;
      @(negedge ps_clk_i);
    end
    n = 0;
    while (mmcm_rst_o === 1'b0 && n < 70000) begin
      n++;
      @(negedge ps_clk_i);
    end
    vec++;
    if (n != 65535) begin
      miss++;
      $display("FAIL lock_tmo_len: %0d cycles want 65535", n);
    end
    vec++;
    if (mmcm_rst_o !== 1'b1 || {err_o, err_code_o} !== 3'b110) begin
      miss++;
      $display("FAIL lock_tmo: mrst=%b err=%b code=%b want 1,1,10",
               mmcm_rst_o, err_o, err_code_o);
    end
    lock_en = 1'b1;
    wait_ready(300);
    vec++;
    if (phase_o !== 10'd0 || locked_o !== 1'b1) begin
      miss++;
      $display("FAIL lock_rec: phase=%0d lk=%b want 0,1",
               phase_o, locked_o);
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_step5();
    test_goto();
    test_noop_cmds();
    test_ps_timeout();
    test_lock_loss();
    test_reset_mid();
    test_lock_never();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
